plr_elastic: RTL and testbench

Parametrised elastic pipeline register: a chain of `DEPTH` stages, each holding up to two `WIDTH`-bit words (main + skid entry), with valid/ready handshaking on both sides, synchronous flush, and a NOP value driven on empty output. It is the next-generation replacement for the fixed enable-only pipeline registers between CPU stages. Backpressure propagates one stage per cycle instead of freezing the whole pipe. Branch/hazard logic can squash in-flight words.

---
 rtl/plr_elastic.sv | 141 ++++++++++++++
 tb/tb_plr_elastic.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plr_elastic.sv
// rtl/plr_elastic.sv - elastic pipeline register chain, two-entry stages with skid, flush and NOP output
module plr_elastic #(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [WIDTH-1:0]                 i_in_data,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [WIDTH-1:0]                 o_out_data,
    input  logic                             i_flush,
    output logic [$clog2(2*DEPTH+1)-1:0]     o_occupancy
);
    localparam int OCC_W = $clog2(2*DEPTH+1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    stage_state_e     r_state     [DEPTH];
    stage_state_e     w_state_nxt [DEPTH];
    logic [WIDTH-1:0] r_main      [DEPTH];
    logic [WIDTH-1:0] r_skid      [DEPTH];
    logic [WIDTH-1:0] w_up_data   [DEPTH];
    logic [DEPTH-1:0] w_up_valid, w_up_ready, w_dn_valid, w_dn_ready;
    logic [DEPTH-1:0] w_up_fire, w_dn_fire;
    logic [DEPTH-1:0] w_main_from_up, w_main_from_skid, w_skid_load;
    logic [OCC_W-1:0] r_occ;
    logic             w_in_fire, w_out_fire;

    // Ready is derived from registered state only, so out_ready never reaches in_ready.
    always_comb begin
        w_up_valid = '0;
        w_dn_ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_up_ready[k] = (r_state[k] != ST_FULL);
            w_dn_valid[k] = (r_state[k] != ST_EMPTY);
            w_up_data[k]  = i_in_data;
        end
        w_up_valid[0] = i_in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = w_dn_valid[k-1];
            w_up_data[k]  = r_main[k-1];
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_dn_ready[k] = w_up_ready[k+1];
        end
        w_dn_ready[DEPTH-1] = i_out_ready;
        w_up_fire = w_up_valid & w_up_ready;
        w_dn_fire = w_dn_valid & w_dn_ready;
    end

    always_comb begin
        w_main_from_up   = '0;
        w_main_from_skid = '0;
        w_skid_load      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                ST_EMPTY: begin
                    if (w_up_fire[k]) begin
                        w_state_nxt[k]    = ST_HALF;
                        w_main_from_up[k] = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (w_up_fire[k] && w_dn_fire[k]) begin
                        w_main_from_up[k] = 1'b1;
                    end else if (w_up_fire[k]) begin
                        w_state_nxt[k] = ST_FULL;
                        w_skid_load[k] = 1'b1;
                    end else if (w_dn_fire[k]) begin
                        w_state_nxt[k] = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_dn_fire[k]) begin
                        w_state_nxt[k]      = ST_HALF;
                        w_main_from_skid[k] = 1'b1;
                    end
                end
                default: w_state_nxt[k] = ST_EMPTY;
            endcase
            if (i_flush) begin
                w_state_nxt[k] = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_state[k] <= ST_EMPTY;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (w_main_from_up[k]) begin
                r_main[k] <= w_up_data[k];
            end else if (w_main_from_skid[k]) begin
                r_main[k] <= r_skid[k];
            end
            if (w_skid_load[k]) begin
                r_skid[k] <= w_up_data[k];
            end
        end
    end

    assign w_in_fire  = w_up_fire[0];
    assign w_out_fire = w_dn_fire[DEPTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ <= '0;
        end else if (i_flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign o_in_ready  = w_up_ready[0];
    assign o_out_valid = w_dn_valid[DEPTH-1];
    assign o_out_data  = w_dn_valid[DEPTH-1] ? r_main[DEPTH-1] : NOP_VALUE;
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_plr_elastic.sv
// tb/tb_plr_elastic.sv - self-checking bench for plr_elastic over four width/depth configurations
module tb_plr_elastic;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv  [4];
    logic        orr [4];
    logic        fl  [4];
    logic [31:0] id  [4];
    logic        ov  [4];
    logic        ir  [4];
    logic [31:0] od  [4];
    logic [4:0]  occ [4];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] got_d [$];
    int          got_c [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    generate
        for (genvar g = 0; g < 4; g++) begin : g_cfg
            localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
            localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : (g == 2) ? 1 : 32;
            localparam logic [W-1:0] NOP = (g == 0) ? W'(16'hF000) : {W{1'b1}};
            localparam int OW = $clog2(2*D+1);

            logic [W-1:0]  w_od;
            logic [OW-1:0] w_occ;
            logic          w_ov, w_ir;

            plr_elastic #(.WIDTH(W), .DEPTH(D), .NOP_VALUE(NOP)) u_dut (
                .i_clk       (clk),
                .i_rst_n     (rst_n),
                .i_in_valid  (iv[g]),
                .o_in_ready  (w_ir),
                .i_in_data   (id[g][W-1:0]),
                .o_out_valid (w_ov),
                .i_out_ready (orr[g]),
                .o_out_data  (w_od),
                .i_flush     (fl[g]),
                .o_occupancy (w_occ)
            );

            assign ov[g]  = w_ov;
            assign ir[g]  = w_ir;
            assign od[g]  = 32'(w_od);
            assign occ[g] = 5'(w_occ);

            // Reference: one FIFO of words plus a word count per stage.
            int           cnt [D];
            logic [W-1:0] q [$];

            always @(posedge clk or negedge rst_n) begin : model
                int nc [D];
                bit inf, outf;
                if (!rst_n) begin
                    q.delete();
                    foreach (cnt[k]) cnt[k] = 0;
                end else begin
                    inf  = iv[g] && (cnt[0] < 2);
                    outf = orr[g] && (cnt[D-1] > 0);
                    foreach (cnt[k]) nc[k] = cnt[k];
                    nc[0]   += int'(inf);
                    nc[D-1] -= int'(outf);
                    for (int k = 0; k < D - 1; k++) begin
                        if (cnt[k] > 0 && cnt[k+1] < 2) begin
                            nc[k]--;
                            nc[k+1]++;
                        end
                    end
                    if (fl[g]) begin
                        q.delete();
                        foreach (nc[k]) nc[k] = 0;
                    end else begin
                        if (outf) void'(q.pop_front());
                        if (inf) q.push_back(id[g][W-1:0]);
                    end
                    foreach (cnt[k]) cnt[k] = nc[k];
                end
            end

            always @(negedge clk) begin : cmp
                logic         ev;
                logic [W-1:0] ed;
                ev = (cnt[D-1] > 0);
                ed = NOP;
                if (ev && q.size() > 0) ed = q[0];
                check($sformatf("g%0d out_valid", g), 32'(w_ov), 32'(ev));
                check($sformatf("g%0d out_data", g), 32'(w_od), 32'(ed));
                check($sformatf("g%0d in_ready", g), 32'(w_ir), 32'(cnt[0] < 2));
                check($sformatf("g%0d occupancy", g), 32'(w_occ), 32'(q.size()));
            end
        end
    endgenerate

    always @(negedge clk) begin
        if (rst_n && ov[0] && orr[0]) begin
            got_d.push_back(od[0]);
            got_c.push_back(cyc);
        end
    end

    initial begin
        int n0, n, f;
        bit acc [4];
        int thr;
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0; orr[g] = 1'b0; fl[g] = 1'b0; id[g] = '0; acc[g] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;

        @(negedge clk);
        check("idle out_valid", 32'(ov[0]), 32'd0);
        check("idle out_data", od[0], 32'hF000);
        check("idle in_ready", 32'(ir[0]), 32'd1);
        check("idle occupancy", 32'(occ[0]), 32'd0);
        tick();

        got_d.delete(); got_c.delete();
        orr[0] = 1'b1;
        n0 = 0;
        for (int i = 1; i <= 16; i++) begin
            iv[0] = 1'b1;
            id[0] = 32'(i);
            @(negedge clk);
            if (i >= 4) check("stream occupancy", 32'(occ[0]), 32'd3);
            tick();
            if (i == 1) n0 = cyc;
        end
        iv[0] = 1'b0;
        repeat (6) tick();
        check("stream count", 32'(got_d.size()), 32'd16);
        for (int j = 0; j < got_d.size() && j < 16; j++) begin
            check("stream data", got_d[j], 32'(j + 1));
            check("stream timing", 32'(got_c[j]), 32'(n0 + 2 + j));
        end

        got_d.delete(); got_c.delete();
        orr[0] = 1'b0;
        n = 0;
        for (int it = 0; it < 12; it++) begin
            id[0] = 32'hA0 + 32'(n);
            iv[0] = 1'b1;
            @(negedge clk);
            acc[0] = ir[0];
            tick();
            if (acc[0]) n++;
        end
        @(negedge clk);
        check("backpressure accepted", 32'(n), 32'd6);
        check("backpressure in_ready", 32'(ir[0]), 32'd0);
        check("backpressure occupancy", 32'(occ[0]), 32'd6);
        orr[0] = 1'b1;
        #1;
        check("in_ready same-cycle out_ready", 32'(ir[0]), 32'd0);
        tick();
        for (int it = 0; it < 10; it++) begin
            id[0] = 32'hA0 + 32'(n);
            iv[0] = 1'b1;
            @(negedge clk);
            acc[0] = ir[0];
            tick();
            if (acc[0]) n++;
        end
        iv[0] = 1'b0;
        repeat (12) tick();
        check("recovery count", 32'(got_d.size()), 32'(n));
        for (int j = 0; j < got_d.size(); j++) begin
            check("recovery data", got_d[j], 32'hA0 + 32'(j));
        end

        got_d.delete(); got_c.delete();
        orr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[0] = 1'b1;
            id[0] = 32'hC0 + 32'(i);
            tick();
        end
        id[0] = 32'hBEEF;
        fl[0] = 1'b1;
        @(negedge clk);
        check("flush pre occupancy", 32'(occ[0]), 32'd4);
        check("flush pre in_ready", 32'(ir[0]), 32'd1);
        tick();
        fl[0] = 1'b0;
        f = cyc;
        id[0] = 32'h1234;
        orr[0] = 1'b1;
        @(negedge clk);
        check("flush occupancy", 32'(occ[0]), 32'd0);
        check("flush out_valid", 32'(ov[0]), 32'd0);
        check("flush out_data", od[0], 32'hF000);
        check("flush in_ready", 32'(ir[0]), 32'd1);
        tick();
        iv[0] = 1'b0;
        repeat (6) tick();
        check("post-flush count", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) begin
            check("post-flush data", got_d[0], 32'h1234);
            check("post-flush timing", 32'(got_c[0]), 32'(f + 3));
        end

        orr[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'hD0;
        repeat (8) tick();
        iv[0] = 1'b0;
        @(negedge clk);
        check("full before reset", 32'(occ[0]), 32'd6);
        check("valid before reset", 32'(ov[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(ov[0]), 32'd0);
        check("async reset occupancy", 32'(occ[0]), 32'd0);
        check("async reset in_ready", 32'(ir[0]), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        thr = 4;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) thr = $urandom_range(1, 7);
            for (int g = 0; g < 4; g++) begin
                if (!(iv[g] && !acc[g])) begin
                    iv[g] = ($urandom % 4) != 0;
                    id[g] = $urandom;
                end
                orr[g] = ($urandom % 8) < thr;
                fl[g]  = ($urandom % 150) == 0;
            end
            @(negedge clk);
            for (int g = 0; g < 4; g++) acc[g] = ir[g];
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0; fl[g] = 1'b0; orr[g] = 1'b1;
        end
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
